sipo_frame_rx: RTL and testbench

- Downstream consumer of the D flip-flop stage. Takes the registered serial bit stream (the flop's Q) and deframes it into parallel words.
- Frame format: start bit (0), WIDTH data bits LSB-first, optional parity bit, stop bit (1).
- Delivers each received word through a valid/ready handshake and flags framing, overrun and parity errors.
- Sits between the flip-flop capture stage and any word-level consumer.

---
 rtl/sipo_frame_rx.sv | 150 +++++++++++++++
 tb/tb_sipo_frame_rx.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/sipo_frame_rx.sv
// Serial-to-parallel frame receiver: start(0), WIDTH data bits LSB-first, stop(1).
// Define SIPO_FRAME_RX_PARITY_EN to add an even-parity bit between data and stop.
module sipo_frame_rx #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             d,
    input  logic             en,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    input  logic             ready,
    output logic             busy,
    output logic             frame_err,
    output logic             overrun,
    output logic             parity_err,
    input  logic             err_clr
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef SIPO_FRAME_RX_PARITY_EN
    typedef enum logic [2:0] {
        ARM,
        IDLE,
        SHIFT,
        PAR,
        STOP
    } state_t;
`else
    typedef enum logic [2:0] {
        ARM,
        IDLE,
        SHIFT,
        STOP
    } state_t;
`endif

    state_t           state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] shift_reg;

`ifdef SIPO_FRAME_RX_PARITY_EN
    logic par_bad;
`else
    assign parity_err = 1'b0;
`endif

    always_comb begin
        busy = 1'b0;
        unique case (state)
            SHIFT:   busy = 1'b1;
`ifdef SIPO_FRAME_RX_PARITY_EN
            PAR:     busy = 1'b1;
`endif
            STOP:    busy = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ARM;
            count     <= '0;
            shift_reg <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef SIPO_FRAME_RX_PARITY_EN
            parity_err <= 1'b0;
            par_bad    <= 1'b0;
`endif
        end else begin
            // clears first so a same-edge error event below overrides them
            if (err_clr) begin
                frame_err <= 1'b0;
                overrun   <= 1'b0;
`ifdef SIPO_FRAME_RX_PARITY_EN
                parity_err <= 1'b0;
`endif
            end
            if (valid && ready) begin
                valid <= 1'b0;
            end
            if (en) begin
                unique case (state)
                    ARM: begin
                        if (d) begin
                            state <= IDLE;
                        end
                    end
                    IDLE: begin
                        if (!d) begin
                            state <= SHIFT;
                            count <= '0;
                        end
                    end
                    SHIFT: begin
                        shift_reg[count] <= d;
                        count            <= count + 1'b1;
                        if (count == LAST) begin
`ifdef SIPO_FRAME_RX_PARITY_EN
                            state <= PAR;
`else
                            state <= STOP;
`endif
                        end
                    end
`ifdef SIPO_FRAME_RX_PARITY_EN
                    PAR: begin
                        par_bad <= (d != ^shift_reg);
                        state   <= STOP;
                    end
`endif
                    STOP: begin
                        if (!d) begin
                            frame_err <= 1'b1;
                            state     <= ARM;
                        end else begin
                            state <= IDLE;
`ifdef SIPO_FRAME_RX_PARITY_EN
                            if (par_bad) begin
                                parity_err <= 1'b1;
                            end else if (!valid || ready) begin
                                data  <= shift_reg;
                                valid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
`else
                            if (!valid || ready) begin
                                data  <= shift_reg;
                                valid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
`endif
                        end
                    end
                    default: begin
                        state <= ARM;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sipo_frame_rx.sv
// Directed bench for sipo_frame_rx (WIDTH=8), parity build optional via
// SIPO_FRAME_RX_PARITY_EN.
module tb_sipo_frame_rx;

    logic       clk = 1'b0;
    logic       reset;
    logic       d;
    logic       en;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       busy;
    logic       frame_err;
    logic       overrun;
    logic       parity_err;
    logic       err_clr;

    int   errs   = 0;
    int   checks = 0;
    logic busy_all;
    logic pre_valid;
    logic trk = 1'b0;

    always #5 clk = ~clk;

    sipo_frame_rx #(.WIDTH(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .d          (d),
        .en         (en),
        .data       (data),
        .valid      (valid),
        .ready      (ready),
        .busy       (busy),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .parity_err (parity_err),
        .err_clr    (err_clr)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // gap idle edges (en=0, d inverted) then one strobed edge carrying b
    task automatic strobe(input logic b, input int gap,
                          input logic r, input logic c);
        for (int i = 0; i < gap; i++) begin
            @(negedge clk);
            d = ~b; en = 1'b0; ready = 1'b0; err_clr = 1'b0;
            @(posedge clk);
            #1;
            if (trk) busy_all &= busy;
        end
        @(negedge clk);
        d = b; en = 1'b1; ready = r; err_clr = c;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cyc(input logic r, input logic c);
        @(negedge clk);
        d = 1'b1; en = 1'b0; ready = r; err_clr = c;
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] v, input logic stop,
                              input logic pbad, input int gap,
                              input logic rs, input logic cs);
        logic pbit;
        pbit = (^v) ^ pbad;
        trk = 1'b0;
        strobe(1'b0, gap, 1'b0, 1'b0);
        busy_all = busy;
        trk = 1'b1;
        for (int i = 0; i < 8; i++) begin
            strobe(v[i], gap, 1'b0, 1'b0);
            busy_all &= busy;
        end
`ifdef SIPO_FRAME_RX_PARITY_EN
        strobe(pbit, gap, 1'b0, 1'b0);
        busy_all &= busy;
`else
        busy_all &= (busy | pbit) & busy;
`endif
        pre_valid = valid;
        strobe(stop, gap, rs, cs);
        trk = 1'b0;
    endtask

    initial begin
        reset = 1'b0; d = 1'b1; en = 1'b1; ready = 1'b0; err_clr = 1'b0;
        #12;
        check("rst_data", data, 8'h00);
        check("rst_valid", valid, 0);
        check("rst_busy", busy, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_ovr", overrun, 0);
        check("rst_perr", parity_err, 0);
        reset = 1'b1;
        strobe(1'b1, 0, 1'b0, 1'b0);
        check("idle_busy", busy, 0);
        check("idle_valid", valid, 0);

        send_frame(8'hA5, 1'b1, 1'b0, 0, 1'b0, 1'b0);
        check("gf_pre_valid", pre_valid, 0);
        check("gf_valid", valid, 1);
        check("gf_data", data, 8'hA5);
        check("gf_busy_frame", busy_all, 1);
        check("gf_busy_after", busy, 0);
        idle_cyc(1'b1, 1'b0);
        check("gf_consume", valid, 0);
        check("gf_data_hold", data, 8'hA5);

        send_frame(8'hA5, 1'b1, 1'b0, 2, 1'b0, 1'b0);
        check("gap_pre_valid", pre_valid, 0);
        check("gap_valid", valid, 1);
        check("gap_data", data, 8'hA5);
        check("gap_busy", busy_all, 1);
        idle_cyc(1'b1, 1'b0);
        check("gap_consume", valid, 0);

        send_frame(8'h3C, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        check("fe_flag", frame_err, 1);
        check("fe_valid", valid, 0);
        check("fe_busy", busy, 0);
        check("fe_data", data, 8'hA5);
        strobe(1'b0, 0, 1'b0, 1'b0);
        check("fe_arm_hold", busy, 0);
        strobe(1'b1, 0, 1'b0, 1'b0);
        check("fe_idle", busy, 0);
        send_frame(8'h5A, 1'b1, 1'b0, 0, 1'b0, 1'b0);
        check("fe_next_valid", valid, 1);
        check("fe_next_data", data, 8'h5A);
        check("fe_sticky", frame_err, 1);
        idle_cyc(1'b1, 1'b1);
        check("fe_clr", frame_err, 0);
        check("fe_consume", valid, 0);

        send_frame(8'h11, 1'b1, 1'b0, 0, 1'b0, 1'b0);
        check("ov_first", data, 8'h11);
        check("ov_first_ovr", overrun, 0);
        send_frame(8'h22, 1'b1, 1'b0, 0, 1'b0, 1'b0);
        check("ov_flag", overrun, 1);
        check("ov_data", data, 8'h11);
        check("ov_valid", valid, 1);
        idle_cyc(1'b1, 1'b0);
        check("ov_consume", valid, 0);
        send_frame(8'h11, 1'b1, 1'b0, 0, 1'b0, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0, 0, 1'b1, 1'b0);
        check("sim_data", data, 8'h22);
        check("sim_valid", valid, 1);
        check("sim_ovr", overrun, 1);
        idle_cyc(1'b1, 1'b1);
        check("sim_clr", overrun, 0);
        check("sim_consume", valid, 0);

        send_frame(8'h3C, 1'b0, 1'b0, 0, 1'b0, 1'b1);
        check("win_ferr", frame_err, 1);
        idle_cyc(1'b0, 1'b1);
        check("win_clr", frame_err, 0);
        strobe(1'b1, 0, 1'b0, 1'b0);

`ifdef SIPO_FRAME_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b0, 0, 1'b0, 1'b0);
        check("par_ok_data", data, 8'h07);
        check("par_ok_valid", valid, 1);
        check("par_ok_perr", parity_err, 0);
        idle_cyc(1'b1, 1'b0);
        send_frame(8'h07, 1'b1, 1'b1, 0, 1'b0, 1'b0);
        check("par_bad_perr", parity_err, 1);
        check("par_bad_valid", valid, 0);
        check("par_bad_ovr", overrun, 0);
        idle_cyc(1'b0, 1'b1);
        check("par_clr", parity_err, 0);
`else
        send_frame(8'h07, 1'b1, 1'b0, 0, 1'b0, 1'b0);
        check("nopar_data", data, 8'h07);
        check("nopar_valid", valid, 1);
        check("nopar_perr", parity_err, 0);
        idle_cyc(1'b1, 1'b0);
        send_frame(8'h08, 1'b1, 1'b1, 0, 1'b0, 1'b0);
        check("nopar_data2", data, 8'h08);
        check("nopar_perr2", parity_err, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
